data_ram: RTL and testbench

- Single-clock, parametrised simple-dual-port data memory for the core's load/store path.
- One read port and one write port.
- Features: per-byte write strobes, configurable read latency with a valid flag, and a post-reset hardware clear sequencer that zeroes every cell.
- Sits between the load/store unit and the data bus; busy tells the pipeline when the memory is usable.

---
 rtl/data_ram_pkg.sv | 31 +++
 rtl/data_ram_clear_fsm.sv | 51 +++++
 rtl/data_ram.sv | 109 ++++++++++
 tb/tb_data_ram.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data_ram memory.
// Optional build macro: DATA_RAM_BYPASS_EN (write-first collision bypass).
package data_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    // Widest word merge_bytes handles; callers zero-extend into this width.
    localparam int MERGE_MAX_W = 512;

    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

    // Byte-lane merge: lanes with strb set take new_w, the rest keep old_w.
    function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
        input logic [MERGE_MAX_W-1:0]   old_w,
        input logic [MERGE_MAX_W-1:0]   new_w,
        input logic [MERGE_MAX_W/8-1:0] strb
    );
        logic [MERGE_MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_ram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once writing zero,
// holding busy high until the last cell is cleared.
module data_ram_clear_fsm
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and clear pointer registers; reset restarts the sweep at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: one cell per edge while clearing, RUN after the last one.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy     = 1'b0;
        clear_we = 1'b0;
        case (state_q)
            CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == '1) state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign clear_addr = ptr_q;

endmodule

// File: rtl/data_ram.sv
// Simple-dual-port data memory with byte strobes, 1- or 2-cycle read
// latency and a post-reset hardware clear.
// Optional build macro: DATA_RAM_BYPASS_EN selects write-first behaviour
// on a same-address read/write collision; default is read-first.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = nbytes(DATA_W);

    generate
        if (DATA_W % 8 != 0 || DATA_W > MERGE_MAX_W || DATA_W < 8)
            $error("data_ram: DATA_W must be a multiple of 8 in [8, MERGE_MAX_W]");
        if (READ_LAT != 1 && READ_LAT != 2)
            $error("data_ram: READ_LAT must be 1 or 2");
    endgenerate

    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;

    data_ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    logic [DATA_W-1:0] cells [DEPTH];

    logic rd_acc, wr_acc;
    assign rd_acc = rd_en & ~busy;
    assign wr_acc = wr_en & ~busy;

    logic [MERGE_MAX_W-1:0]   old_ext, new_ext, mrg_ext;
    logic [MERGE_MAX_W/8-1:0] strb_ext;
    logic [DATA_W-1:0]        wr_merged;
    logic                     unused_mrg;

    // Byte merge of the addressed cell with the incoming write word.
    always_comb begin
        old_ext  = '0;
        new_ext  = '0;
        strb_ext = '0;
        old_ext[DATA_W-1:0] = cells[wr_addr];
        new_ext[DATA_W-1:0] = wr_data;
        strb_ext[NB-1:0]    = wr_strb;
        mrg_ext   = merge_bytes(old_ext, new_ext, strb_ext);
        wr_merged = mrg_ext[DATA_W-1:0];
    end
    assign unused_mrg = ^mrg_ext;

    // Array write port: the clear sweep owns it while busy.
    always_ff @(posedge clk) begin
        if (clear_we)    cells[clear_addr] <= '0;
        else if (wr_acc) cells[wr_addr]    <= wr_merged;
    end

    logic [DATA_W-1:0] rd_word;

    // First-stage read word, optionally forwarding a colliding write.
    always_comb begin
        rd_word = cells[rd_addr];
`ifdef DATA_RAM_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) rd_word = wr_merged;
`endif
    end

    logic [READ_LAT:0] vld_pipe;
    logic [DATA_W-1:0] dat_pipe [READ_LAT:1];

    assign vld_pipe[0] = rd_acc;

    // Read pipeline: stage 1 samples the array, later stages only register.
    // Each data stage loads only alongside its valid so rd_data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[READ_LAT:1] <= '0;
            for (int k = 1; k <= READ_LAT; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[READ_LAT:1] <= vld_pipe[READ_LAT-1:0];
            if (rd_acc) dat_pipe[1] <= rd_word;
            for (int k = 2; k <= READ_LAT; k++) begin
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign rd_data  = dat_pipe[READ_LAT];
    assign rd_valid = vld_pipe[READ_LAT];

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: one READ_LAT=1 and one READ_LAT=2 instance
// share the same stimulus and are checked against hand-computed values.
module tb_data_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

`ifdef DATA_RAM_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'h0000BEEF;
`else
    localparam logic [31:0] COLL_EXP = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;

    logic        busy1, busy2, rd_valid1, rd_valid2;
    logic [31:0] rd_data1, rd_data2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .busy(busy1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .busy(busy2),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    typedef struct {
        logic        re;
        logic [7:0]  ra;
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; wr_strb = '0;
    endtask

    function automatic vec_t rd(input logic [7:0] a, input logic [31:0] e);
        vec_t v;
        v = '{re: 1'b1, ra: a, we: 1'b0, wa: 8'h0, wd: 32'h0, ws: 4'h0, exp: e};
        return v;
    endfunction

    function automatic vec_t wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v = '{re: 1'b0, ra: 8'h0, we: 1'b1, wa: a, wd: d, ws: s, exp: 32'h0};
        return v;
    endfunction

    // Counts edges until busy drops on both copies; gated requests are
    // optionally held asserted to prove they are ignored.
    task automatic run_clear(input string tag, input bit poke);
        int cnt;
        bit saw_vld;
        cnt = 0;
        saw_vld = 0;
        if (poke) begin
            rd_en = 1'b1; rd_addr = 8'h03;
            wr_en = 1'b1; wr_addr = 8'h03; wr_data = 32'h12345678; wr_strb = 4'hF;
        end
        while ((busy1 || busy2) && cnt < 600) begin
            tick();
            cnt++;
            if (rd_valid1 || rd_valid2) saw_vld = 1;
            if (!busy1 && !busy2) idle();
        end
        idle();
        check({tag, "_clear_edges"}, 32'(cnt), 32'(DEPTH));
        check({tag, "_busy_low"}, {30'h0, busy2, busy1}, 32'h0);
        if (poke) check({tag, "_no_valid_while_busy"}, {31'h0, saw_vld}, 32'h0);
    endtask

    logic        prev_re;
    logic [31:0] prev_exp, last1, last2;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {30'h0, busy2, busy1}, 32'h3);
        check("rst_valid", {30'h0, rd_valid2, rd_valid1}, 32'h0);
        check("rst_data1", rd_data1, 32'h0);
        check("rst_data2", rd_data2, 32'h0);
        rst_n = 1'b1;
        #1;
        check("busy_after_release", {30'h0, busy2, busy1}, 32'h3);

        // Clear sweep with gated write/read to addr 3
        run_clear("init", 1'b1);

        // Directed vector table
        vecs.push_back(rd(8'h03, 32'h0));
        vecs.push_back(rd(8'h00, 32'h0));
        vecs.push_back(rd(8'h7F, 32'h0));
        vecs.push_back(rd(8'hFF, 32'h0));
        vecs.push_back(wr(8'h05, 32'hAABBCCDD, 4'b1111));
        vecs.push_back(wr(8'h05, 32'h11223344, 4'b0101));
        vecs.push_back(rd(8'h05, 32'hAA22CC44));
        vecs.push_back(wr(8'h01, 32'h1, 4'hF));
        vecs.push_back(wr(8'h02, 32'h2, 4'hF));
        vecs.push_back(wr(8'h03, 32'h3, 4'hF));
        vecs.push_back(rd(8'h01, 32'h1));
        vecs.push_back(rd(8'h02, 32'h2));
        vecs.push_back(rd(8'h03, 32'h3));
        vecs.push_back(wr(8'h00, 32'h0, 4'h0));
        vecs.push_back(wr(8'h00, 32'h0, 4'h0));
        vecs.push_back('{re: 1'b1, ra: 8'h09, we: 1'b1, wa: 8'h09,
                         wd: 32'hDEADBEEF, ws: 4'b0011, exp: COLL_EXP});
        vecs.push_back(rd(8'h09, 32'h0000BEEF));
        vecs.push_back(wr(8'hFF, 32'hFFFFFFFF, 4'b0000));
        vecs.push_back(rd(8'hFF, 32'h0));
        vecs.push_back(wr(8'h7F, 32'h5A6B7C8D, 4'b1000));
        vecs.push_back(rd(8'h7F, 32'h5A000000));

        prev_re = 1'b0; prev_exp = '0; last1 = '0; last2 = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            wr_en = vecs[i].we; wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd; wr_strb = vecs[i].ws;
            tick();
            if (vecs[i].re) last1 = vecs[i].exp;
            if (prev_re) last2 = prev_exp;
            check($sformatf("v%0d_valid_l1", i), {31'h0, rd_valid1}, {31'h0, vecs[i].re});
            check($sformatf("v%0d_data_l1", i), rd_data1, last1);
            check($sformatf("v%0d_valid_l2", i), {31'h0, rd_valid2}, {31'h0, prev_re});
            check($sformatf("v%0d_data_l2", i), rd_data2, last2);
            prev_re = vecs[i].re;
            prev_exp = vecs[i].exp;
        end
        idle();
        tick();
        check("tail_valid_l2", {31'h0, rd_valid2}, {31'h0, prev_re});
        check("tail_data_l2", rd_data2, prev_exp);
        tick();
        check("hold_valid_l2", {31'h0, rd_valid2}, 32'h0);
        check("hold_data_l2", rd_data2, prev_exp);

        // Reset while a READ_LAT=2 read of addr 5 is in flight
        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        idle();
        check("inflight_l1", rd_data1, 32'hAA22CC44);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {30'h0, rd_valid2, rd_valid1}, 32'h0);
        check("midrst_data1", rd_data1, 32'h0);
        check("midrst_data2", rd_data2, 32'h0);
        check("midrst_busy", {30'h0, busy2, busy1}, 32'h3);
        #1 rst_n = 1'b1;
        run_clear("rerun", 1'b0);

        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        idle();
        check("post_rst_valid_l1", {31'h0, rd_valid1}, 32'h1);
        check("post_rst_data_l1", rd_data1, 32'h0);
        rd_en = 1'b1; rd_addr = 8'h7F;
        tick();
        idle();
        check("post_rst_valid_l2", {31'h0, rd_valid2}, 32'h1);
        check("post_rst_data_l2", rd_data2, 32'h0);
        check("post_rst_7f_l1", rd_data1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
